// File: rtl/text_line_ctrl.sv
// Character line store for the ASCII font renderer: accepts typed codes, keeps a write cursor,
// and blanks the whole line one cell per cycle on clear or carriage return.
module text_line_ctrl #(
  parameter int NUM_CHARS = 40,
  parameter int IDX_W     = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_char,
  output logic                   in_ready,
  input  logic                   clear,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [7:0]             rd_char,
  output logic [NUM_CHARS*8-1:0] line_out,
  output logic [IDX_W-1:0]       cursor,
  output logic                   full,
  output logic                   busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(NUM_CHARS);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_sweep_idx;
  logic [IDX_W-1:0] r_cursor;
  logic [IDX_W-1:0] w_cursor_nxt;
  logic [7:0]       r_cells [NUM_CHARS];
  logic [7:0]       r_rd_char;

  logic             w_xfer;
  logic             w_printable;
  logic             w_full;
  logic             w_start_sweep;
  logic             w_wr_en;
  logic [IDX_W-1:0] w_wr_idx;
  logic [7:0]       w_wr_data;
  logic [7:0]       w_rd_val;

  assign w_xfer        = in_valid && in_ready;
  assign w_printable   = (in_char >= 8'h20) && (in_char <= 8'h7E);
  assign w_full        = (r_cursor == END_IDX);
  assign w_start_sweep = (r_state == ST_IDLE) && (clear || (w_xfer && (in_char == CH_CR)));

  // State register; the sweep index parks at 0 whenever no sweep is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sweep_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_SWEEP) && (r_sweep_idx != LAST_IDX)) begin
        r_sweep_idx <= r_sweep_idx + 1'b1;
      end else begin
        r_sweep_idx <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_sweep) w_state_nxt = ST_SWEEP;
      ST_SWEEP: if (r_sweep_idx == LAST_IDX) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Gating with rst keeps in_ready low while reset is held even though the state reads IDLE.
  always_comb begin
    busy     = (r_state == ST_SWEEP);
    in_ready = (r_state == ST_IDLE) && !clear && !rst;
  end

  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_idx     = '0;
    w_wr_data    = '0;
    w_cursor_nxt = r_cursor;
    if (r_state == ST_SWEEP) begin
      w_wr_en  = 1'b1;
      w_wr_idx = r_sweep_idx;
    end else if (clear) begin
      w_cursor_nxt = '0;
    end else if (w_xfer) begin
      if (w_printable) begin
        if (!w_full) begin
          w_wr_en      = 1'b1;
          w_wr_idx     = r_cursor;
          w_wr_data    = in_char;
          w_cursor_nxt = r_cursor + 1'b1;
        end
      end else if (in_char == CH_BS) begin
        if (r_cursor != '0) begin
          w_wr_en      = 1'b1;
          w_wr_idx     = r_cursor - 1'b1;
          w_cursor_nxt = r_cursor - 1'b1;
        end
      end else if (in_char == CH_CR) begin
        w_cursor_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CHARS; k++) r_cells[k] <= '0;
    end else if (w_wr_en) begin
      for (int k = 0; k < NUM_CHARS; k++) begin
        if (w_wr_idx == IDX_W'(k)) r_cells[k] <= w_wr_data;
      end
    end
  end

  // Indices beyond the line match no cell and therefore read as blank.
  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_CHARS; k++) begin
      if (rd_idx == IDX_W'(k)) w_rd_val = r_cells[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cursor  <= '0;
      r_rd_char <= '0;
    end else begin
      r_cursor  <= w_cursor_nxt;
      r_rd_char <= w_rd_val;
    end
  end

  for (genvar g = 0; g < NUM_CHARS; g++) begin : g_line
    assign line_out[g*8 +: 8] = r_cells[g];
  end

  assign cursor  = r_cursor;
  assign full    = w_full;
  assign rd_char = r_rd_char;

endmodule
